// File: rtl/uart_byte_rx.sv
`timescale 1ns/1ps
// uart_byte_rx
// 8N1 UART receiver. The serial line is double-flopped, a start bit is
// qualified at its mid-point, and each data and stop bit is sampled one
// full bit time after the previous sample, so every sample lands at mid-bit.
// A good stop bit publishes the byte on 'data' with a one-cycle 'valid'
// pulse. A low stop bit gives a one-cycle 'frame_err' pulse instead. The
// receiver then waits for the line to return high before it looks for the
// next start bit.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  // Last count of a full bit period, and the count that marks a half bit.
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MID_CNT  = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  // Synchronizer flops. Both reset high so that reset does not look like a
  // start bit.
  logic        rx_meta_r;
  logic        rx_sync_r;
  logic        rx_s;

  // FSM state and datapath registers.
  state_t      state_r;
  logic [15:0] cnt_r;
  logic [2:0]  idx_r;
  logic [7:0]  shift_r;
  logic [7:0]  data_r;
  logic        valid_r;
  logic        ferr_r;
  logic        busy_r;

  // Next-state values computed by the combinational half of the FSM.
  state_t      state_nxt_s;
  logic [15:0] cnt_nxt_s;
  logic [2:0]  idx_nxt_s;
  logic [7:0]  shift_nxt_s;
  logic [7:0]  data_nxt_s;
  logic        valid_nxt_s;
  logic        ferr_nxt_s;

  assign rx_s      = rx_sync_r;
  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = ferr_r;
  assign busy      = busy_r;

  // Two-flop synchronizer that brings the asynchronous rx line into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state, counter, shift-register and output-pulse decode for the receive FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    data_nxt_s  = data_r;
    valid_nxt_s = 1'b0;
    ferr_nxt_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = 16'd0;
        if (rx_s == 1'b0) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_r == MID_CNT) begin
          cnt_nxt_s = 16'd0;
          if (rx_s == 1'b0) begin
            state_nxt_s = ST_DATA;
            idx_nxt_s   = 3'd0;
          end else begin
            // The line went high again before mid-bit, so this was a glitch.
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end

      ST_DATA: begin
        if (cnt_r == LAST_CNT) begin
          shift_nxt_s[idx_r] = rx_s;
          cnt_nxt_s          = 16'd0;
          idx_nxt_s          = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end

      ST_STOP: begin
        if (cnt_r == LAST_CNT) begin
          cnt_nxt_s = 16'd0;
          if (rx_s == 1'b1) begin
            data_nxt_s  = shift_r;
            valid_nxt_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            ferr_nxt_s  = 1'b1;
            state_nxt_s = ST_WAIT_HIGH;
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end

      ST_WAIT_HIGH: begin
        // A low line here is the tail of a broken frame, not a start bit.
        cnt_nxt_s = 16'd0;
        if (rx_s == 1'b1) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_HIGH;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 16'd0;
        idx_nxt_s   = 3'd0;
      end
    endcase
  end

  // State, datapath and registered-output update. Reset overrides any pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 16'd0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      ferr_r  <= ferr_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
`timescale 1ns/1ps
// tb_uart_byte_rx
// Self-checking bench for uart_byte_rx with CLKS_PER_BIT = 8. Every frame
// the bench sends adds one entry to an expected-event list. The entry holds
// the pulse type, the data value due at that pulse, and the cycle it is due
// in, all taken from the frame timing rules. A negedge monitor records every
// pulse the DUT produces, and drain() pairs recorded pulses with expected ones.
module tb_uart_byte_rx;

  localparam int C    = 8;
  localparam int HALF = (C - 1) / 2;
  // Clock edges from the first edge that sees rx low to the edge that raises valid.
  localparam int LAT  = 2 + HALF + 9 * C + 1;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_byte_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         at;
  } evt_t;

  typedef struct {
    bit         is_err;
    bit         both;
    bit         consec;
    logic [7:0] d;
    int         at;
  } obs_t;

  typedef struct {
    logic [7:0] b;
    logic       stop_bit;
    int         low_extra;
    int         gap;
    int         exp_v;
    int         exp_e;
    logic [7:0] exp_data;
  } vec_t;

  evt_t       exp_q[$];
  obs_t       obs_q[$];
  logic [7:0] model_data = 8'h00;
  int         fall_at = 0;
  int         checks = 0;
  int         errors = 0;
  int         n_valid = 0;
  int         n_err = 0;
  int         last_valid_at = 0;
  int         prev_valid_at = 0;
  bit         prev_pulse = 1'b0;

  // Record every output pulse, together with any overlap or back-to-back pulses.
  always @(negedge clk) begin
    obs_t o;
    if (valid === 1'b1 || frame_err === 1'b1) begin
      o.is_err = (frame_err === 1'b1);
      o.both   = (valid === 1'b1) && (frame_err === 1'b1);
      o.consec = prev_pulse;
      o.d      = data;
      o.at     = cyc;
      obs_q.push_back(o);
    end
    prev_pulse = (valid === 1'b1) || (frame_err === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc < target) begin
      errors++;
      $display("FAIL wait_timeout actual=%0d expected=%0d", cyc, target);
    end
  endtask

  task automatic drain();
    obs_t o;
    evt_t x;
    int   dt;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      chk("pulse_overlap", 32'(o.both), 32'd0);
      chk("pulse_consecutive", 32'(o.consec), 32'd0);
      if (o.is_err) begin
        n_err++;
      end else begin
        n_valid++;
        prev_valid_at = last_valid_at;
        last_valid_at = o.at;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual=err:%0b@%0d expected=none", o.is_err, o.at);
      end else begin
        x  = exp_q.pop_front();
        dt = o.at - x.at;
        if (o.is_err != x.is_err || dt > 1 || dt < -1 || o.d !== x.d) begin
          errors++;
          $display("FAIL pulse actual=err:%0b data:%h cyc:%0d expected=err:%0b data:%h cyc:%0d",
                   o.is_err, o.d, o.at, x.is_err, x.d, x.at);
        end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int low_extra,
                            input int gap, input bit expect_evt);
    evt_t e;
    fall_at = cyc;
    if (expect_evt) begin
      e.is_err = !stop_bit;
      e.d      = stop_bit ? b : model_data;
      e.at     = fall_at + 1 + LAT;
      exp_q.push_back(e);
      if (stop_bit) model_data = b;
    end
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
    if (!stop_bit) repeat (low_extra) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    int v0;
    int e0;
    int g_at;

    vecs[0] = '{8'hB0, 1'b1, 0,  4, 1, 0, 8'hB0};
    vecs[1] = '{8'h3C, 1'b1, 0,  4, 1, 0, 8'h3C};
    vecs[2] = '{8'hAA, 1'b1, 0,  4, 1, 0, 8'hAA};
    vecs[3] = '{8'h00, 1'b0, 20, 6, 0, 1, 8'hAA};
    vecs[4] = '{8'h00, 1'b1, 0,  4, 1, 0, 8'h00};
    vecs[5] = '{8'h7E, 1'b0, 0,  5, 0, 1, 8'h00};
    vecs[6] = '{8'h81, 1'b1, 0,  4, 1, 0, 8'h81};

    // Check the reset state while reset is held.
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table of single frames.
    for (int k = 0; k < 7; k++) begin
      drain();
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[k].b, vecs[k].stop_bit, vecs[k].low_extra, vecs[k].gap, 1'b1);
      drain();
      chk($sformatf("vec%0d_valid_count", k), 32'(n_valid - v0), 32'(vecs[k].exp_v));
      chk($sformatf("vec%0d_err_count", k), 32'(n_err - e0), 32'(vecs[k].exp_e));
      chk($sformatf("vec%0d_data", k), 32'(data), 32'(vecs[k].exp_data));
      chk($sformatf("vec%0d_busy_after", k), 32'(busy), 32'd0);
    end

    // Back-to-back frames with a single stop bit each.
    v0 = n_valid;
    send_frame(8'hB1, 1'b1, 0, 0, 1'b1);
    send_frame(8'hFF, 1'b1, 0, 6, 1'b1);
    drain();
    chk("b2b_valid_count", 32'(n_valid - v0), 32'd2);
    chk("b2b_spacing", 32'(last_valid_at - prev_valid_at), 32'd80);
    chk("b2b_data", 32'(data), 32'hFF);

    // A two-cycle glitch is rejected at the start-bit mid-point.
    v0 = n_valid;
    e0 = n_err;
    g_at = cyc;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    wait_cyc(g_at + 4);
    chk("glitch_busy_mid", 32'(busy), 32'd1);
    wait_cyc(g_at + 9);
    chk("glitch_busy_after", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    drain();
    chk("glitch_no_valid", 32'(n_valid - v0), 32'd0);
    chk("glitch_no_err", 32'(n_err - e0), 32'd0);
    chk("glitch_data", 32'(data), 32'hFF);

    // A bad stop bit with the line held low: the receiver stays busy, then recovers.
    send_frame(8'hAA, 1'b1, 0, 4, 1'b1);
    e0 = n_err;
    fork
      send_frame(8'h00, 1'b0, 20, 6, 1'b1);
      begin
        @(negedge clk);
        wait_cyc(fall_at + 90);
        chk("waithigh_busy", 32'(busy), 32'd1);
        chk("waithigh_data", 32'(data), 32'hAA);
      end
    join
    drain();
    chk("waithigh_err_count", 32'(n_err - e0), 32'd1);
    send_frame(8'h00, 1'b1, 0, 4, 1'b1);
    drain();
    chk("recover_data", 32'(data), 32'h00);

    // Reset pulse during data bit 4. The rest of the frame is all ones, so the line looks idle.
    send_frame(8'h5C, 1'b1, 0, 4, 1'b1);
    fork
      send_frame(8'hF5, 1'b1, 0, 4, 1'b0);
      begin
        @(negedge clk);
        wait_cyc(fall_at + 46);
        chk("rst_data_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_data = 8'h00;
        chk("rst_data_data", 32'(data), 32'h00);
        chk("rst_data_valid", 32'(valid), 32'd0);
        chk("rst_data_frame_err", 32'(frame_err), 32'd0);
        chk("rst_data_busy", 32'(busy), 32'd0);
      end
    join
    drain();
    send_frame(8'hB3, 1'b1, 0, 4, 1'b1);
    drain();
    chk("after_rst_data", 32'(data), 32'hB3);

    // Reset on the exact edge that would raise valid suppresses that pulse.
    v0 = n_valid;
    fork
      send_frame(8'h5A, 1'b1, 0, 4, 1'b0);
      begin
        @(negedge clk);
        wait_cyc(fall_at + LAT);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_data = 8'h00;
      end
    join
    repeat (4) @(negedge clk);
    drain();
    chk("rst_stop_no_valid", 32'(n_valid - v0), 32'd0);
    chk("rst_stop_data", 32'(data), 32'h00);

    // Random frames with random stop bits, low-hold times and idle gaps.
    for (int r = 0; r < 40; r++) begin
      logic [7:0] b;
      logic       good;
      int         lx;
      int         gp;
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      lx   = int'($urandom_range(0, 15));
      gp   = good ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
      send_frame(b, good, lx, gp, 1'b1);
      drain();
    end
    repeat (20) @(negedge clk);
    drain();
    chk("all_expected_seen", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_data", 32'(data), 32'(model_data));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
